// File: rtl/transmission_recip_te.sv
// Transmission estimate t = 1 - product, clamped to T0, with a 14-stage restoring divider for 1/t.
// Build option TE_ROUND_EN: when defined, 1/t is rounded to nearest instead of truncated.
module transmission_recip_te #(
  parameter int T0   = 103,
  parameter int SB_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  input  logic [9:0]      product,
  input  logic [SB_W-1:0] sb_in,
  output logic            out_valid,
  output logic [10:0]     t,
  output logic [13:0]     inv_t,
  output logic [SB_W-1:0] sb_out
);

  localparam int NS = 14;

  logic [10:0] t_raw;
  logic [10:0] t_c;
  logic [20:0] dvd;

  assign t_raw = 11'd1024 - {1'b0, product};
  assign t_c   = (t_raw < 11'(T0)) ? 11'(T0) : t_raw;

`ifdef TE_ROUND_EN
  assign dvd = 21'h100000 + {11'd0, t_c[10:1]};
`else
  assign dvd = 21'h100000;
`endif

  // Index 0 is the clamp stage; indices 1..NS are the divider stages.
  logic            vld    [0:NS];
  logic [10:0]     tc     [0:NS];
  logic [SB_W-1:0] sb     [0:NS];
  logic [20:0]     rem    [0:NS-1];
  logic [13:0]     quo    [1:NS];
  logic [NS-1:0]   qbit;
  logic [20:0]     rem_nx [1:NS-1];

  // Stage i resolves quotient bit NS-i by trial-subtracting the shifted divisor.
  for (genvar i = 1; i <= NS; i++) begin : g_div
    localparam int B = NS - i;
    logic [24:0] dsh;
    assign dsh     = {14'd0, tc[i-1]} << B;
    assign qbit[B] = ({4'd0, rem[i-1]} >= dsh);
    if (i < NS) begin : g_rem
      assign rem_nx[i] = qbit[B] ? (rem[i-1] - dsh[20:0]) : rem[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NS; i++) begin
        vld[i] <= 1'b0;
        tc[i]  <= '0;
        sb[i]  <= '0;
      end
      for (int i = 0; i < NS; i++) rem[i] <= '0;
      for (int i = 1; i <= NS; i++) quo[i] <= '0;
    end else if (en) begin
      vld[0] <= in_valid;
      tc[0]  <= t_c;
      sb[0]  <= sb_in;
      rem[0] <= dvd;
      for (int i = 1; i <= NS; i++) begin
        vld[i] <= vld[i-1];
        tc[i]  <= tc[i-1];
        sb[i]  <= sb[i-1];
      end
      for (int i = 1; i < NS; i++) rem[i] <= rem_nx[i];
      quo[1] <= {qbit[NS-1], 13'd0};
      for (int i = 2; i <= NS; i++) quo[i] <= quo[i-1] | (14'(qbit[NS-i]) << (NS-i));
    end
  end

  assign out_valid = vld[NS];
  assign t         = tc[NS];
  assign inv_t     = quo[NS];
  assign sb_out    = sb[NS];

endmodule

// File: tb/tb_transmission_recip_te.sv
// Self-checking bench for transmission_recip_te: directed boundary cases plus randomized traffic
// with stalls and resets, scored against an arithmetic reference model keyed on enabled-cycle count.
module tb_transmission_recip_te;

  localparam int SB_W = 24;
  localparam int LAT  = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            in_valid = 1'b0;
  logic [9:0]      product = '0;
  logic [SB_W-1:0] sb_in = '0;
  logic            out_valid;
  logic [10:0]     t;
  logic [13:0]     inv_t;
  logic [SB_W-1:0] sb_out;

  transmission_recip_te #(.T0(103), .SB_W(SB_W)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .product(product), .sb_in(sb_in),
    .out_valid(out_valid), .t(t), .inv_t(inv_t), .sb_out(sb_out)
  );

  always #5 clk = ~clk;

  typedef struct { int k; int tv; int inv; int sbv; } ent_t;
  ent_t q[$];

  int ecnt = 0;
  int n_pass = 0;
  int n_chk = 0;
  bit started = 1'b0;
  bit exp_ov = 1'b0;
  bit exp_zero = 1'b0;
  int exp_t = 0, exp_inv = 0, exp_sb = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (time %0t)", tag, obs, exp_v, $time);
  endtask

  function automatic int model_t(input int p);
    int r;
    r = 1024 - p;
    return (r < 103) ? 103 : r;
  endfunction

  function automatic int model_inv(input int tv);
`ifdef TE_ROUND_EN
    return ((1 << 20) + tv / 2) / tv;
`else
    return (1 << 20) / tv;
`endif
  endfunction

  // Reference: each accepted sample is due exactly LAT enabled edges after acceptance.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      q.delete();
      started  = 1'b1;
      exp_ov   = 1'b0;
      exp_zero = 1'b1;
      exp_t = 0; exp_inv = 0; exp_sb = 0;
    end else if (en) begin
      if (in_valid) begin
        ent_t e;
        e.k   = ecnt;
        e.tv  = model_t(int'(product));
        e.inv = model_inv(e.tv);
        e.sbv = int'(sb_in);
        q.push_back(e);
      end
      ecnt++;
      exp_zero = 1'b0;
      exp_ov   = 1'b0;
      if (q.size() > 0 && q[0].k + LAT == ecnt) begin
        exp_ov  = 1'b1;
        exp_t   = q[0].tv;
        exp_inv = q[0].inv;
        exp_sb  = q[0].sbv;
        void'(q.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("out_valid", int'(out_valid), int'(exp_ov));
      if (exp_ov || exp_zero) begin
        chk("t", int'(t), exp_t);
        chk("inv_t", int'(inv_t), exp_inv);
        chk("sb_out", int'(sb_out), exp_sb);
      end
    end
  end

  task automatic step(input bit v, input int p, input int s, input bit e);
    in_valid = v;
    product  = 10'(p);
    sb_in    = SB_W'(s);
    en       = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step(0, 0, 0, 1);
    rst = 1'b0;

    step(1, 0, 24'hABCDEF, 1);
    repeat (20) step(0, 0, 0, 1);

    step(1, 1023, 1, 1);
    step(1, 921, 2, 1);
    step(1, 920, 3, 1);
    step(1, 410, 4, 1);
    repeat (20) step(0, 0, 0, 1);

    for (int i = 0; i < 32; i++) step(1, i, i, 1);
    repeat (20) step(0, 0, 0, 1);

    // Stall: 8 samples, en low for 5 cycles starting at cycle 10.
    for (int c = 0; c < 30; c++) step(c < 8, 100 + c * 37, c, !(c >= 10 && c < 15));

    // Mid-stream reset at cycle 7 of a 10-sample stream.
    for (int c = 0; c < 30; c++) begin
      rst = (c == 7);
      step(c < 10, 500 + c * 50, 16'h1000 + c, 1);
    end
    rst = 1'b0;

    for (int c = 0; c < 400; c++) begin
      rst = ($urandom % 100) == 0;
      step(($urandom % 2) == 0, int'($urandom_range(0, 1023)), int'($urandom % (1 << SB_W)),
           ($urandom % 8) != 0);
    end
    rst = 1'b0;

    repeat (25) step(0, 0, 0, 1);
    chk("drain_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
